// File: rtl/lamp_pkg.sv
// Shared types and default constants for the lamp fade driver.
// States use a fixed 2-bit encoding so status decodes stay stable.
package lamp_pkg;

  typedef enum logic [1:0] {
    ST_OFF       = 2'b00,
    ST_RAMP_UP   = 2'b01,
    ST_ON        = 2'b10,
    ST_RAMP_DOWN = 2'b11
  } lamp_state_e;

  localparam int unsigned PWM_BITS_DEF = 8;
  localparam int unsigned RAMP_DIV_DEF = 256;
  localparam int unsigned LAMPS_DEF    = 6;

endpackage : lamp_pkg

// File: rtl/lamp_fade_driver_if.sv
// Room-light interface between the lighting controller (master) and the
// lamp fade driver (slave): request levels in, PWM drive and status out.
interface lamp_fade_driver_if #(
  parameter int unsigned LAMPS = 6
);

  logic [LAMPS-1:0] target;
  logic             enable;
  logic [LAMPS-1:0] lamp_pwm;
  logic [LAMPS-1:0] lamp_on;
  logic             all_settled;

  modport master (
    output target,
    output enable,
    input  lamp_pwm,
    input  lamp_on,
    input  all_settled
  );

  modport slave (
    input  target,
    input  enable,
    output lamp_pwm,
    output lamp_on,
    output all_settled
  );

endinterface : lamp_fade_driver_if

// File: rtl/lamp_channel.sv
// One lamp channel: fade FSM, brightness level, duty mapping and the
// registered PWM compare. Optional macro LAMP_GAMMA_EN selects a squared
// (perceptually linear) duty curve instead of duty == level.
module lamp_channel
  import lamp_pkg::*;
#(
  parameter int unsigned PWM_BITS = PWM_BITS_DEF
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                target_i,
  input  logic                tick_i,
  input  logic [PWM_BITS-1:0] pwm_cnt_i,
  output logic                pwm_o,
  output logic                on_o,
  output logic                settled_o
);

  localparam logic [PWM_BITS-1:0] LVL_MAX  = {PWM_BITS{1'b1}};
  localparam logic [PWM_BITS-1:0] LVL_ZERO = {PWM_BITS{1'b0}};
  localparam logic [PWM_BITS-1:0] LVL_ONE  = PWM_BITS'(1);

  lamp_state_e         state_q, state_d;
  logic [PWM_BITS-1:0] level_q, level_d;
  logic [PWM_BITS-1:0] level_up_s, level_dn_s, duty_s;
  logic                pwm_q, pwm_d;
  logic                on_q, on_d;
  logic                settled_q, settled_d;

  // Brightness-to-duty mapping; full level always gives a constant-high output.
  function automatic logic [PWM_BITS-1:0] duty_map(input logic [PWM_BITS-1:0] lvl);
`ifdef LAMP_GAMMA_EN
    logic [2*PWM_BITS-1:0] sq;
    sq = {{PWM_BITS{1'b0}}, lvl} * {{PWM_BITS{1'b0}}, lvl};
    if (lvl == LVL_MAX) begin
      duty_map = LVL_MAX;
    end else begin
      duty_map = sq[2*PWM_BITS-1:PWM_BITS];
    end
`else
    duty_map = lvl;
`endif
  endfunction

  // Saturating neighbours of the current level.
  always_comb begin
    level_up_s = (level_q == LVL_MAX)  ? LVL_MAX  : level_q + LVL_ONE;
    level_dn_s = (level_q == LVL_ZERO) ? LVL_ZERO : level_q - LVL_ONE;
    duty_s     = duty_map(level_q);
  end

  // Fade FSM: a target change wins over a tick; steps only happen on ticks.
  always_comb begin
    state_d = state_q;
    level_d = level_q;
    case (state_q)
      ST_OFF: begin
        if (target_i) state_d = ST_RAMP_UP;
        else          state_d = ST_OFF;
      end
      ST_RAMP_UP: begin
        if (!target_i) begin
          state_d = ST_RAMP_DOWN;
        end else if (tick_i) begin
          level_d = level_up_s;
          if (level_up_s == LVL_MAX) state_d = ST_ON;
          else                       state_d = ST_RAMP_UP;
        end else begin
          state_d = ST_RAMP_UP;
        end
      end
      ST_ON: begin
        if (!target_i) state_d = ST_RAMP_DOWN;
        else           state_d = ST_ON;
      end
      ST_RAMP_DOWN: begin
        if (target_i) begin
          state_d = ST_RAMP_UP;
        end else if (tick_i) begin
          level_d = level_dn_s;
          if (level_dn_s == LVL_ZERO) state_d = ST_OFF;
          else                        state_d = ST_RAMP_DOWN;
        end else begin
          state_d = ST_RAMP_DOWN;
        end
      end
      default: begin
        state_d = ST_OFF;
        level_d = LVL_ZERO;
      end
    endcase
  end

  // Output next-values: PWM compare on the current duty, status from next state.
  always_comb begin
    pwm_d     = (duty_s > pwm_cnt_i);
    on_d      = (state_d == ST_ON);
    settled_d = (state_d == ST_OFF) || (state_d == ST_ON);
  end

  // Channel state and registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_OFF;
      level_q   <= LVL_ZERO;
      pwm_q     <= 1'b0;
      on_q      <= 1'b0;
      settled_q <= 1'b1;
    end else begin
      state_q   <= state_d;
      level_q   <= level_d;
      pwm_q     <= pwm_d;
      on_q      <= on_d;
      settled_q <= settled_d;
    end
  end

  assign pwm_o     = pwm_q;
  assign on_o      = on_q;
  assign settled_o = settled_q;

endmodule : lamp_channel

// File: rtl/lamp_fade_driver.sv
// Lamp fade driver top: shared ramp prescaler and PWM counter feeding
// LAMPS independent fade channels. Optional macro LAMP_GAMMA_EN (see
// lamp_channel) changes only the duty curve.
module lamp_fade_driver
  import lamp_pkg::*;
#(
  parameter int unsigned PWM_BITS = PWM_BITS_DEF,
  parameter int unsigned RAMP_DIV = RAMP_DIV_DEF,
  parameter int unsigned LAMPS    = LAMPS_DEF
) (
  input  logic               clk,
  input  logic               reset,
  lamp_fade_driver_if.slave  lamp_bus
);

  localparam int unsigned PS_W = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
  localparam logic [PS_W-1:0]     PS_LAST  = PS_W'(RAMP_DIV - 1);
  localparam logic [PS_W-1:0]     PS_ONE   = PS_W'(1);
  localparam logic [PWM_BITS-1:0] CNT_LAST = PWM_BITS'((2 ** PWM_BITS) - 2);
  localparam logic [PWM_BITS-1:0] CNT_ONE  = PWM_BITS'(1);

  logic [PS_W-1:0]     presc_q, presc_d;
  logic [PWM_BITS-1:0] pwm_cnt_q, pwm_cnt_d;
  logic                tick_s;
  logic [LAMPS-1:0]    pwm_s, on_s, settled_s;

  // Ramp tick and next counter values; the PWM counter ignores enable.
  always_comb begin
    tick_s = lamp_bus.enable && (presc_q == PS_LAST);
    if (!lamp_bus.enable) presc_d = presc_q;
    else if (tick_s)      presc_d = {PS_W{1'b0}};
    else                  presc_d = presc_q + PS_ONE;
    if (pwm_cnt_q == CNT_LAST) pwm_cnt_d = {PWM_BITS{1'b0}};
    else                       pwm_cnt_d = pwm_cnt_q + CNT_ONE;
  end

  // Shared prescaler and PWM counter registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      presc_q   <= {PS_W{1'b0}};
      pwm_cnt_q <= {PWM_BITS{1'b0}};
    end else begin
      presc_q   <= presc_d;
      pwm_cnt_q <= pwm_cnt_d;
    end
  end

  for (genvar g = 0; g < LAMPS; g++) begin : g_ch
    lamp_channel #(.PWM_BITS(PWM_BITS)) u_ch (
      .clk       (clk),
      .reset     (reset),
      .target_i  (lamp_bus.target[g]),
      .tick_i    (tick_s),
      .pwm_cnt_i (pwm_cnt_q),
      .pwm_o     (pwm_s[g]),
      .on_o      (on_s[g]),
      .settled_o (settled_s[g])
    );
  end

  assign lamp_bus.lamp_pwm    = pwm_s;
  assign lamp_bus.lamp_on     = on_s;
  assign lamp_bus.all_settled = &settled_s;

endmodule : lamp_fade_driver

// File: tb/tb_lamp_fade_driver.sv
// Self-checking bench for lamp_fade_driver with PWM_BITS=4, RAMP_DIV=2.
// The reference model tracks each lamp as (level, heading, moving) and
// is compared against the DUT after every clock edge.
module tb_lamp_fade_driver;

  localparam int PWM_BITS = 4;
  localparam int RAMP_DIV = 2;
  localparam int LAMPS    = 6;
  localparam int MAX      = 15;

  logic clk;
  logic reset;

  lamp_fade_driver_if #(.LAMPS(LAMPS)) bus ();

  lamp_fade_driver #(.PWM_BITS(PWM_BITS), .RAMP_DIV(RAMP_DIV), .LAMPS(LAMPS)) dut (
    .clk      (clk),
    .reset    (reset),
    .lamp_bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_pass;
  int n_total;

  // reference model
  int m_presc;
  int m_pwm;
  int m_lvl    [LAMPS];
  bit m_goal   [LAMPS];
  bit m_moving [LAMPS];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
  endtask

  function automatic int duty_of(input int lvl);
`ifdef LAMP_GAMMA_EN
    if (lvl == MAX) return MAX;
    return (lvl * lvl) / (MAX + 1);
`else
    return lvl;
`endif
  endfunction

  task automatic model_reset();
    m_presc = 0;
    m_pwm   = 0;
    for (int i = 0; i < LAMPS; i++) begin
      m_lvl[i]    = 0;
      m_goal[i]   = 1'b0;
      m_moving[i] = 1'b0;
    end
  endtask

  // One clock: advance the model from the inputs seen at the edge, then compare.
  task automatic step();
    bit tick;
    logic [LAMPS-1:0] exp_pwm, exp_on;
    bit exp_settled;
    @(posedge clk);
    tick = bus.enable && (m_presc == RAMP_DIV - 1);
    exp_pwm = '0;
    for (int i = 0; i < LAMPS; i++) begin
      exp_pwm[i] = (duty_of(m_lvl[i]) > m_pwm);
      if (bus.target[i] != m_goal[i]) begin
        m_goal[i]   = bus.target[i];
        m_moving[i] = 1'b1;
      end else if (m_moving[i] && tick) begin
        if (m_goal[i]) m_lvl[i] = (m_lvl[i] < MAX) ? m_lvl[i] + 1 : MAX;
        else           m_lvl[i] = (m_lvl[i] > 0) ? m_lvl[i] - 1 : 0;
        if ((m_goal[i] && m_lvl[i] == MAX) || (!m_goal[i] && m_lvl[i] == 0))
          m_moving[i] = 1'b0;
      end
    end
    if (bus.enable) m_presc = tick ? 0 : m_presc + 1;
    m_pwm = (m_pwm + 1) % MAX;
    exp_on = '0;
    exp_settled = 1'b1;
    for (int i = 0; i < LAMPS; i++) begin
      exp_on[i] = m_goal[i] && !m_moving[i];
      if (m_moving[i]) exp_settled = 1'b0;
    end
    #1;
    chk("lamp_pwm", 32'(bus.lamp_pwm), 32'(exp_pwm));
    chk("lamp_on", 32'(bus.lamp_on), 32'(exp_on));
    chk("all_settled", 32'(bus.all_settled), 32'(exp_settled));
  endtask

  // Async reset: outputs must clear before any clock edge.
  task automatic do_reset();
    reset = 1'b1;
    #1;
    chk("rst_pwm", 32'(bus.lamp_pwm), 32'h0);
    chk("rst_on", 32'(bus.lamp_on), 32'h0);
    chk("rst_settled", 32'(bus.all_settled), 32'h1);
    model_reset();
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    int cnt;
    n_pass = 0;
    n_total = 0;
    bus.target = '0;
    bus.enable = 1'b1;
    do_reset();

    // lamp 0 fades fully on
    bus.target = 6'b000001;
    for (int k = 0; k < 40; k++) step();
    chk("up_level", 32'(m_lvl[0]), 32'd15);
    chk("up_on", 32'(bus.lamp_on), 32'h01);
    chk("up_settled", 32'(bus.all_settled), 32'h1);
    cnt = 0;
    for (int k = 0; k < 15; k++) begin step(); cnt += int'(bus.lamp_pwm[0]); end
    chk("full_duty", 32'(cnt), 32'd15);

    // lamp 0 fades fully off
    bus.target = 6'b000000;
    step();
    chk("down_busy", 32'(bus.all_settled), 32'h0);
    for (int k = 0; k < 40; k++) step();
    chk("down_on", 32'(bus.lamp_on), 32'h0);
    chk("down_settled", 32'(bus.all_settled), 32'h1);

    // ramp to 7, freeze, measure duty, then reverse from 7
    bus.target = 6'b000001;
    for (int k = 0; k < 100 && m_lvl[0] != 7; k++) step();
    chk("reach7", 32'(m_lvl[0]), 32'd7);
    bus.enable = 1'b0;
    step();
    cnt = 0;
    for (int k = 0; k < 15; k++) begin step(); cnt += int'(bus.lamp_pwm[0]); end
`ifdef LAMP_GAMMA_EN
    chk("duty7", 32'(cnt), 32'd3);
`else
    chk("duty7", 32'(cnt), 32'd7);
`endif
    bus.target = 6'b000000;
    bus.enable = 1'b1;
    cnt = 0;
    for (int k = 0; k < 60 && !bus.all_settled; k++) begin step(); cnt++; end
    chk("rev_clocks", 32'(cnt), 32'd14);
    chk("rev_off", 32'(bus.lamp_on), 32'h0);

    // all lamps requested while disabled, then released together
    do_reset();
    bus.target = 6'b111111;
    bus.enable = 1'b0;
    for (int k = 0; k < 20; k++) step();
    chk("dis_pwm", 32'(bus.lamp_pwm), 32'h0);
    chk("dis_settled", 32'(bus.all_settled), 32'h0);
    bus.enable = 1'b1;
    for (int k = 0; k < 60 && bus.lamp_on == 6'b000000; k++) step();
    chk("all_on_same_edge", 32'(bus.lamp_on), 32'h3F);

    // randomized targets and enable
    do_reset();
    for (int k = 0; k < 1500; k++) begin
      if ($urandom_range(0, 19) == 0) bus.target = 6'($urandom);
      bus.enable = ($urandom_range(0, 7) != 0);
      step();
    end

    // reset while every lamp sits at level 10
    bus.enable = 1'b1;
    bus.target = 6'b000000;
    do_reset();
    bus.target = 6'b111111;
    for (int k = 0; k < 60 && m_lvl[0] != 10; k++) step();
    chk("reach10", 32'(m_lvl[0]), 32'd10);
    chk("mid_settled", 32'(bus.all_settled), 32'h0);
    do_reset();
    for (int k = 0; k < 4; k++) step();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule : tb_lamp_fade_driver
